// File: rtl/regfile_write_sequencer.sv
// Register-file write sequencer: queues write-back requests in a small FIFO and
// replays each one as a SETUP / STROBE / HOLD pulse on the register-file port.
module regfile_write_sequencer #(
  parameter int DEPTH     = 4,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        regWrite,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        pending1,
  output logic        pending2,
  output logic        busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [4:0]         reg_mem  [DEPTH];
  logic [31:0]        data_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [DEPTH-1:0]   entry_valid;
  logic [PTR_W-1:0]   slot_offset;
  logic               accept;
  logic               drop;
  logic               push;
  logic               pop;
  logic               in_flight;

  // Readiness looks only at the registered count, so a pop in the same cycle
  // never frees a slot for that cycle's request.
  assign wb_ready = (count < CNT_W'(DEPTH));
  assign accept   = wb_valid & wb_ready;
  assign drop     = DROP_ZERO && (wb_reg == 5'd0);
  assign push     = accept & ~drop;

  // ---------------------------------------------------------------------------
  // Sequencing FSM: next state and pop decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = STROBE;
      STROBE: state_next = HOLD;
      HOLD: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output set is flop-driven; regWrite is high exactly while in STROBE.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      regWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      state    <= state_next;
      regWrite <= (state_next == STROBE);
      if (pop) begin
        write_reg  <= reg_mem[rd_ptr];
        write_data <= data_mem[rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entry validity comes from the reset
  // pointers and count, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= wb_reg;
      data_mem[wr_ptr] <= wb_data;
    end
  end

  // A slot is occupied when its distance past rd_ptr is below count.
  always_comb begin
    entry_valid = '0;
    slot_offset = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_offset    = PTR_W'(j) - rd_ptr;
      entry_valid[j] = ({1'b0, slot_offset} < count);
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard reporting: queued entries plus the write not yet committed
  // ---------------------------------------------------------------------------
  assign in_flight = (state == SETUP) || (state == STROBE);

  always_comb begin
    pending1 = 1'b0;
    pending2 = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (entry_valid[j] && (reg_mem[j] == chk_reg1)) pending1 = 1'b1;
      if (entry_valid[j] && (reg_mem[j] == chk_reg2)) pending2 = 1'b1;
    end
    if (in_flight && (write_reg == chk_reg1)) pending1 = 1'b1;
    if (in_flight && (write_reg == chk_reg2)) pending2 = 1'b1;
    // Register 0 is never written when zero-writes are dropped.
    if (DROP_ZERO && (chk_reg1 == 5'd0)) pending1 = 1'b0;
    if (DROP_ZERO && (chk_reg2 == 5'd0)) pending2 = 1'b0;
  end

  assign busy = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer: reset, single-write timing, full
// FIFO, register-zero drop, same-register ordering and pointer wrap.
module tb_regfile_write_sequencer;

  localparam int DEPTH     = 4;
  localparam bit DROP_ZERO = 1'b1;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regWrite;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        pending1;
  logic        pending2;
  logic        busy;

  int          n_vectors     = 0;
  int          n_miscompares = 0;
  int          cyc           = 0;
  int          n_commits     = 0;
  logic        rw_prev       = 1'b0;
  logic [36:0] exp_q [$];
  int          commit_cyc [$];
  logic [31:0] model_rf [32];
  logic [36:0] exp_entry;

  regfile_write_sequencer #(
    .DEPTH     (DEPTH),
    .DROP_ZERO (DROP_ZERO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .write_reg  (write_reg),
    .write_data (write_data),
    .regWrite   (regWrite),
    .chk_reg1   (chk_reg1),
    .chk_reg2   (chk_reg2),
    .pending1   (pending1),
    .pending2   (pending2),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Commit monitor: every regWrite rising edge must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && regWrite && !rw_prev) begin
      n_commits <= n_commits + 1;
      commit_cyc.push_back(cyc);
      model_rf[write_reg] <= write_data;
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 32'd1, 32'd0);
      end else begin
        exp_entry = exp_q.pop_front();
        check("commit_reg", {27'd0, write_reg}, {27'd0, exp_entry[36:32]});
        check("commit_data", write_data, exp_entry[31:0]);
      end
    end
    rw_prev <= regWrite;
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [4:0] r, input logic [31:0] d, output int waits);
    waits    = 0;
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    while (wb_ready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) check("send_timeout", 32'd0, 32'd1);
    else if (!(DROP_ZERO && r == 5'd0)) exp_q.push_back({r, d});
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || regWrite !== 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    int c0;
    int total_waits;
    logic [4:0]  r;
    logic [31:0] d;
    logic exp_rw   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_pend [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_reg   = '0;
    wb_data  = '0;
    chk_reg1 = 5'd5;
    chk_reg2 = 5'd9;

    // Reset state
    #3;
    check("rst_regWrite",   regWrite,   0);
    check("rst_write_reg",  write_reg,  0);
    check("rst_write_data", write_data, 0);
    check("rst_busy",       busy,       0);
    check("rst_pending1",   pending1,   0);
    check("rst_pending2",   pending2,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wb_ready", wb_ready, 1);

    // Reset asserted mid-STROBE drops regWrite without a clock edge
    chk_reg1 = 5'd9;
    send(5'd9, 32'hCAFE_0009, w);
    n = 0;
    while (regWrite !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_strobe_seen", regWrite, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_regWrite", regWrite,  0);
    check("t1_async_busy",     busy,      0);
    check("t1_async_wreg",     write_reg, 0);
    check("t1_async_pending1", pending1,  0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_post_ready", wb_ready, 1);
    check("t1_post_busy",  busy,     0);

    // Single write: cycle-exact timing relative to the accepting edge
    chk_reg1 = 5'd5;
    chk_reg2 = 5'd6;
    check("t2_ready", wb_ready, 1);
    wb_valid = 1'b1;
    wb_reg   = 5'd5;
    wb_data  = 32'hDEAD_BEEF;
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    @(negedge clk);
    wb_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_regWrite_k%0d", k), regWrite, exp_rw[k]);
      check($sformatf("t2_pending1_k%0d", k), pending1, exp_pend[k]);
      check($sformatf("t2_pending2_k%0d", k), pending2, 0);
      check($sformatf("t2_busy_k%0d", k),     busy,     exp_busy[k]);
      if (k >= 1) begin
        check($sformatf("t2_wreg_k%0d", k),  write_reg,  5'd5);
        check($sformatf("t2_wdata_k%0d", k), write_data, 32'hDEAD_BEEF);
      end
      @(negedge clk);
    end

    // Full FIFO: six back-to-back requests, count reaches DEPTH after the sixth
    commit_cyc.delete();
    total_waits = 0;
    for (int i = 0; i < 6; i++) begin
      send(5'(10 + i), 32'h1000_0000 + i, w);
      total_waits += w;
    end
    check("t3_no_stall",   total_waits, 0);
    check("t3_ready_full", wb_ready,    0);
    check("t3_busy",       busy,        1);
    wait_idle();
    check("t3_commits", commit_cyc.size(), 6);
    for (int i = 1; i < commit_cyc.size(); i++)
      check($sformatf("t3_gap%0d", i), commit_cyc[i] - commit_cyc[i-1], 3);

    // Register zero: handshake completes, nothing is written
    chk_reg1 = 5'd0;
    c0 = n_commits;
    send(5'd0, 32'd7, w);
    check("t4_handshake", w, 0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_busy_k%0d", k),     busy,     0);
      check($sformatf("t4_regWrite_k%0d", k), regWrite, 0);
      check($sformatf("t4_pending1_k%0d", k), pending1, 0);
      @(negedge clk);
    end
    check("t4_no_commit", n_commits, c0);

    // Same register twice: pending holds until the second write reaches HOLD
    chk_reg1 = 5'd4;
    chk_reg2 = 5'd3;
    c0 = n_commits;
    send(5'd3, 32'd1, w);
    send(5'd3, 32'd2, w);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t5_pending2_k%0d", k), pending2, (k < 5) ? 1 : 0);
      check($sformatf("t5_pending1_k%0d", k), pending1, 0);
      @(negedge clk);
    end
    wait_idle();
    check("t5_commits",  n_commits,   c0 + 2);
    check("t5_final_r3", model_rf[3], 32'd2);

    // Pointer wrap: ten requests with random gaps
    c0 = n_commits;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      send(r, d, w);
    end
    wait_idle();
    check("t6_commits", n_commits - c0, 10);
    check("t6_leftover", exp_q.size(), 0);
    check("t6_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
